// File: rtl/mem_burst_if.sv
// Processor-side burst command, write-beat and read-beat channels between the
// burst address generator (master) and the memory burst responder (slave).
interface mem_burst_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic              rlast;
    logic [DATA_W-1:0] rdata;
    logic              done;

    modport master (
        output req_valid, req_write, req_addr, wvalid, wdata,
        input  req_ready, wready, rvalid, rlast, rdata, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, wvalid, wdata,
        output req_ready, wready, rvalid, rlast, rdata, done
    );
endinterface

// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: turns one burst command into BURST_LEN consecutive
// single-port RAM accesses, then pulses done for one cycle.
module mem_burst_responder #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_burst_if.slave        bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int               BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] base;
    logic              req_ready_q;
    logic              wready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic              done_q;

    // NOTE: all state uses non-blocking assignments so every branch sees the
    // pre-edge values of state, beat and the output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            base        <= '0;
            req_ready_q <= 1'b1;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base        <= bus.req_addr;
                        beat        <= '0;
                        req_ready_q <= 1'b0;
                        if (bus.req_write) begin
                            state    <= WRITE;
                            wready_q <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                WRITE: begin
                    // A low wvalid simply stalls the burst; there is no timeout.
                    if (bus.wvalid) begin
                        if (beat == LAST_BEAT) begin
                            state    <= DONE;
                            wready_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end

                READ: begin
                    // Flags describe the address issued this cycle; the RAM
                    // returns its data on the next cycle, aligned with them.
                    rvalid_q <= 1'b1;
                    rlast_q  <= (beat == LAST_BEAT);
                    if (beat == LAST_BEAT) begin
                        state <= READ_DRAIN;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end

                READ_DRAIN: begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end

                DONE: begin
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    wready_q    <= 1'b0;
                    rvalid_q    <= 1'b0;
                    rlast_q     <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Address wraps silently at 2^ADDR_W.
    assign ram_addr  = base + ADDR_W'(beat);
    assign ram_we    = wready_q & bus.wvalid;
    assign ram_wdata = wready_q ? bus.wdata : '0;

    assign bus.req_ready = req_ready_q;
    assign bus.wready    = wready_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rlast     = rlast_q;
    assign bus.rdata     = rvalid_q ? ram_rdata : '0;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder with a behavioural synchronous RAM.
module tb_mem_burst_responder;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 16;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    mem_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_burst_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem     [0:DEPTH-1];
    bit                written [0:DEPTH-1];
    int                wr_count   = 0;
    int                done_count = 0;

    always @(posedge clk) begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : '0;
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
            wr_count          <= wr_count + 1;
        end
        if (bus.done) done_count <= done_count + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write burst; with stall set, wvalid drops for two cycles at beats 3 and 9.
    task automatic run_write(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] doff,
                             input bit stall);
        int beat;
        int hold;
        int exp_done;
        int w0;
        int d0;
        bit stall_now;
        logic [ADDR_W-1:0] a;
        beat     = 0;
        hold     = 0;
        exp_done = stall ? BURST_LEN + 5 : BURST_LEN + 1;
        w0       = wr_count;
        d0       = done_count;
        @(negedge clk);
        check("wr_idle_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = base;
        bus.wvalid    = 1'b0;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            stall_now = stall && (beat == 3 || beat == 9) && hold < 2;
            if (stall_now) hold++;
            bus.wvalid = (beat < BURST_LEN) && !stall_now;
            bus.wdata  = doff + DATA_W'(beat);
            #1;
            check("wr_ram_we", ram_we, bus.wvalid);
            if (bus.wvalid) check("wr_ram_wdata", ram_wdata, doff + DATA_W'(beat));
            if (beat < BURST_LEN) begin
                a = base + ADDR_W'(beat);
                check("wr_ram_addr", ram_addr, a);
            end
            check("wr_wready", bus.wready, k < exp_done);
            check("wr_done", bus.done, k == exp_done);
            check("wr_req_ready", bus.req_ready, k == exp_done + 1);
            check("wr_rvalid", bus.rvalid, 1'b0);
            if (bus.wvalid) begin
                beat++;
                hold = 0;
            end
        end
        bus.wvalid = 1'b0;
        check("wr_count", wr_count - w0, BURST_LEN);
        check("wr_done_once", done_count - d0, 1);
        for (int i = 0; i < BURST_LEN; i++) begin
            a = base + ADDR_W'(i);
            check("wr_mem", mem[a], doff + DATA_W'(i));
        end
    endtask

    // Read burst: address beat k-1 in cycle k, data in cycle k+1, done at BURST_LEN+2.
    task automatic run_read(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] doff);
        logic [ADDR_W-1:0] a;
        int d0;
        d0 = done_count;
        @(negedge clk);
        check("rd_idle_ready", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = base;
        for (int k = 1; k <= BURST_LEN + 3; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            if (k <= BURST_LEN) begin
                a = base + ADDR_W'(k - 1);
                check("rd_ram_addr", ram_addr, a);
            end
            check("rd_ram_we", ram_we, 1'b0);
            check("rd_rvalid", bus.rvalid, k >= 2 && k <= BURST_LEN + 1);
            if (k >= 2 && k <= BURST_LEN + 1)
                check("rd_rdata", bus.rdata, doff + DATA_W'(k - 2));
            check("rd_rlast", bus.rlast, k == BURST_LEN + 1);
            check("rd_done", bus.done, k == BURST_LEN + 2);
            check("rd_req_ready", bus.req_ready, k == BURST_LEN + 3);
        end
        check("rd_done_once", done_count - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        #3;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ram_addr", ram_addr, 19'h0);
        check("rst_wready", bus.wready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_write(19'h00100, 32'h0, 1'b0);
        run_write(19'h00100, 32'h0, 1'b1);
        run_read(19'h00100, 32'h0);
        run_write(19'h7FFF8, 32'hA000, 1'b0);
        run_read(19'h7FFF8, 32'hA000);

        // Reset at write beat 5, with a read request pulsed while busy.
        w0 = wr_count;
        d0 = done_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 19'h00200;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.req_valid = (k == 2 || k == 3);
            bus.req_write = 1'b0;
            bus.req_addr  = 19'h00300;
            bus.wvalid    = 1'b1;
            bus.wdata     = 32'h55 + 32'(k - 1);
            if (k == 6) rst = 1'b1;
            #1;
            if (k == 2) begin
                check("busy_req_ready", bus.req_ready, 1'b0);
                check("busy_wready", bus.wready, 1'b1);
            end
        end
        check("midrst_ram_we", ram_we, 1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_ram_addr", ram_addr, 19'h0);
        check("midrst_wready", bus.wready, 1'b0);
        bus.wvalid    = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", bus.done, 1'b0);
            check("post_rst_rvalid", bus.rvalid, 1'b0);
            check("post_rst_req_ready", bus.req_ready, 1'b1);
        end
        check("midrst_wr_count", wr_count - w0, 5);
        check("midrst_no_done", done_count - d0, 0);
        check("midrst_mem4", mem[19'h00204], 32'h59);
        check("midrst_mem5_unwritten", written[19'h00205], 1'b0);
        check("busy_req_unwritten", written[19'h00300], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_burst_responder.md
Name: mem_burst_responder

Overview:
Memory-side responder for fixed-length burst transfers issued by the processor's burst address generator. It accepts one burst command (base address, read/write), sequences BURST_LEN consecutive word addresses into a single-port synchronous RAM, and handles per-beat write data or returns per-beat read data. It sits between the processor memory interface and the data RAM and signals burst completion with a one-cycle done pulse.

Parameters:
ADDR_W, 19, address width in words
DATA_W, 32, data word width
BURST_LEN, 16, beats per burst (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  1  burst command valid
req_ready  output  1  responder idle, can accept command
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_W  burst base address
wvalid  input  1  write beat valid
wready  output  1  responder accepts write beat
wdata  input  DATA_W  write beat data
rvalid  output  1  read beat valid
rlast  output  1  final read beat
rdata  output  DATA_W  read beat data
done  output  1  one-cycle burst-complete pulse
ram_addr  output  ADDR_W  RAM address
ram_we  output  1  RAM write enable
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid one cycle after address

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. All state on posedge clk.
- Reset values: state IDLE, beat counter 0, base 0; req_ready=1, wready=0, rvalid=0, rlast=0, rdata=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0.
- States: IDLE, WRITE, READ, READ_DRAIN, DONE.
- IDLE: req_ready=1. On req_valid=1 at clock edge: latch req_addr as base, beat<=0, go WRITE if req_write else READ.
- Command accepted only in IDLE; req_valid while busy ignored (req_ready=0), no queuing.
- ram_addr = (base + beat) mod 2^ADDR_W, combinational from registers; wraps 2^ADDR_W-1 -> 0 silently.
- WRITE: wready=1. Beat accepted on wvalid=1: ram_we=wvalid (combinational), ram_wdata=wdata, beat increments. wvalid=0 stalls, no RAM write, beat held, no timeout. On acceptance of beat BURST_LEN-1 go DONE.
- READ: no backpressure; requester must sink one beat per cycle. One address per cycle, beat 0..BURST_LEN-1 on consecutive cycles, ram_we=0. After issuing beat BURST_LEN-1 go READ_DRAIN.
- Read return: rvalid, rdata registered? No — rdata=ram_rdata, rvalid asserted the cycle after each address issue (registered issue flag); rlast=1 with the beat for address BURST_LEN-1. READ_DRAIN: one cycle carrying the final rvalid/rlast, then DONE.
- Latency: command accepted edge N; read address beat 0 driven cycle N+1, rdata beat 0 valid cycle N+2; last beat at N+1+BURST_LEN; done at N+2+BURST_LEN. Write burst with wvalid held high: done at N+1+BURST_LEN.
- DONE: done=1 for exactly one cycle, req_ready=0; next state IDLE.
- Beat counter width $clog2(BURST_LEN)+1; never exceeds BURST_LEN-1.
- rst asserted mid-burst: immediately returns to reset values; burst abandoned, no done, no further RAM writes; partial writes already committed remain.
- ram_we is never asserted outside WRITE; rvalid never asserted outside READ/READ_DRAIN.

Test Plan:
- Reset then idle: rst pulse -> req_ready=1, ram_we=0, rvalid=0, done=0, ram_addr=0.
- Write burst base 0x00100, wvalid high 16 cycles, wdata=beat index -> RAM 0x00100..0x0010F hold 0..15, done pulse exactly once, 17 cycles after accept.
- Write burst with wvalid low on beats 3 and 9 for 2 cycles each -> no RAM write on stall cycles, final contents identical, done delayed by 4 cycles.
- Read burst base 0x00100 after previous write -> rdata 0..15 on 16 consecutive rvalid cycles, rlast only with 15, done the cycle after rlast.
- Wrap: read burst base 0x7FFF8 -> ram_addr sequence 0x7FFF8..0x7FFFF, 0x00000..0x00007.
- rst asserted at write beat 5, and req_valid pulsed during busy -> after rst, RAM beats 0..4 written only, no done; busy-time request never starts a burst.
